// File: rtl/core_fetch_queue.sv
// Fetch-pair to single-instruction queue between I-cache fetch and decode.
// Optional zero-latency bypass through an empty queue: define FETCH_QUEUE_BYPASS_EN.
module core_fetch_queue #(
    parameter int ATTACHED_INFO_WIDTH = 32,
    parameter int DEPTH               = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr_i,
    input  logic [1:0]                       valid_i,
    input  logic [31:0]                      vpc_i,
    input  logic [63:0]                      inst_i,
    input  logic [ATTACHED_INFO_WIDTH-1:0]   attached_i,
    output logic                             ready_o,
    output logic [1:0]                       valid_o,
    output logic [63:0]                      pc_o,
    output logic [63:0]                      inst_o,
    output logic [2*ATTACHED_INFO_WIDTH-1:0] attached_o,
    input  logic                             ready_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]                    r_pc   [DEPTH];
    logic [31:0]                    r_inst [DEPTH];
    logic [ATTACHED_INFO_WIDTH-1:0] r_att  [DEPTH];
    logic [AW-1:0]                  r_head;
    logic [AW-1:0]                  r_tail;
    logic [CW-1:0]                  r_count;

    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail1;
    logic [AW-1:0] w_wr1_idx;
    logic [31:0]   w_in_pc0;
    logic [31:0]   w_in_pc1;
    logic [1:0]    w_in_n;
    logic [1:0]    w_q_valid;
    logic [1:0]    w_pop_n;
    logic [1:0]    w_push_n;
    logic          w_push;
    logic          w_byp_take;
    logic          w_unused_vpc;

    assign w_unused_vpc = ^vpc_i[2:0];
    assign w_head1      = r_head + AW'(1);
    assign w_tail1      = r_tail + AW'(1);
    assign w_in_pc0     = {vpc_i[31:3], 3'b000};
    assign w_in_pc1     = {vpc_i[31:3], 3'b100};
    assign w_in_n       = {1'b0, valid_i[0]} + {1'b0, valid_i[1]};
    assign w_q_valid    = {r_count >= CW'(2), r_count != '0};

    // Credit is based on registered occupancy only; a same-cycle pop does not help.
    assign ready_o = (r_count <= CW'(DEPTH - 2));

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_byp;
    assign w_byp      = (r_count == '0) && !clr_i && (|valid_i);
    assign w_byp_take = w_byp && ready_i;
`else
    assign w_byp_take = 1'b0;
`endif

    assign w_push    = (|valid_i) && ready_o && !w_byp_take;
    assign w_push_n  = w_push ? w_in_n : 2'd0;
    assign w_pop_n   = ready_i ? ({1'b0, w_q_valid[0]} + {1'b0, w_q_valid[1]}) : 2'd0;
    assign w_wr1_idx = valid_i[0] ? w_tail1 : r_tail;

    always_comb begin
        valid_o    = w_q_valid;
        pc_o       = {r_pc[w_head1], r_pc[r_head]};
        inst_o     = {r_inst[w_head1], r_inst[r_head]};
        attached_o = {r_att[w_head1], r_att[r_head]};
`ifdef FETCH_QUEUE_BYPASS_EN
        if (w_byp) begin
            if (valid_i[0]) begin
                valid_o    = valid_i;
                pc_o       = {w_in_pc1, w_in_pc0};
                inst_o     = inst_i;
                attached_o = {attached_i, attached_i};
            end else begin
                valid_o    = 2'b01;
                pc_o       = {w_in_pc1, w_in_pc1};
                inst_o     = {inst_i[63:32], inst_i[63:32]};
                attached_o = {attached_i, attached_i};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (clr_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
        end
    end

    // Payload is not reset; valid state lives entirely in head/tail/count.
    always_ff @(posedge clk) begin
        if (w_push && !clr_i) begin
            if (valid_i[0]) begin
                r_pc[r_tail]   <= w_in_pc0;
                r_inst[r_tail] <= inst_i[31:0];
                r_att[r_tail]  <= attached_i;
            end
            if (valid_i[1]) begin
                r_pc[w_wr1_idx]   <= w_in_pc1;
                r_inst[w_wr1_idx] <= inst_i[63:32];
                r_att[w_wr1_idx]  <= attached_i;
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(DEPTH));
    a_valid_legal: assert property (@(posedge clk) disable iff (!rst_n) valid_o != 2'b10);

endmodule

// File: tb/tb_core_fetch_queue.sv
// Self-checking bench for core_fetch_queue: directed scenarios plus randomized
// traffic compared every cycle against a queue-based model.
module tb_core_fetch_queue;
    localparam int AIW   = 32;
    localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr_i = 1'b0;
    logic [1:0]      valid_i = 2'b00;
    logic [31:0]     vpc_i = 32'h0;
    logic [63:0]     inst_i = 64'h0;
    logic [AIW-1:0]  attached_i = '0;
    logic            ready_i = 1'b0;
    logic            ready_o;
    logic [1:0]      valid_o;
    logic [63:0]     pc_o;
    logic [63:0]     inst_o;
    logic [2*AIW-1:0] attached_o;

    core_fetch_queue #(.ATTACHED_INFO_WIDTH(AIW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .valid_i(valid_i), .vpc_i(vpc_i),
        .inst_i(inst_i), .attached_i(attached_i), .ready_o(ready_o), .valid_o(valid_o),
        .pc_o(pc_o), .inst_o(inst_o), .attached_o(attached_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]    pc;
        logic [31:0]    inst;
        logic [AIW-1:0] att;
    } ent_t;

    ent_t q[$];
    ent_t inc[$];
    ent_t outv[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void build_inc();
        ent_t e;
        inc.delete();
        for (int k = 0; k < 2; k++) begin
            if (valid_i[k]) begin
                e.pc   = {vpc_i[31:3], (k == 1), 2'b00};
                e.inst = inst_i[32*k +: 32];
                e.att  = attached_i;
                inc.push_back(e);
            end
        end
    endfunction

    function automatic bit byp_now();
        return BYP && (q.size() == 0) && !clr_i && (valid_i != 2'b00);
    endfunction

    // Expected outputs: the oldest two queued entries, or the compacted
    // incoming slots when bypassing an empty queue.
    task automatic compare();
        logic [1:0] ev;
        build_inc();
        outv.delete();
        if (byp_now()) begin
            outv = inc;
        end else begin
            for (int k = 0; k < 2 && k < q.size(); k++) outv.push_back(q[k]);
        end
        ev = (outv.size() == 0) ? 2'b00 : (outv.size() == 1) ? 2'b01 : 2'b11;
        chk("ready_o", {63'h0, ready_o}, {63'h0, (q.size() <= DEPTH - 2)});
        chk("valid_o", {62'h0, valid_o}, {62'h0, ev});
        for (int k = 0; k < outv.size(); k++) begin
            chk($sformatf("pc_slot%0d", k),   {32'h0, pc_o[32*k +: 32]},   {32'h0, outv[k].pc});
            chk($sformatf("inst_slot%0d", k), {32'h0, inst_o[32*k +: 32]}, {32'h0, outv[k].inst});
            chk($sformatf("att_slot%0d", k),  {32'h0, attached_o[AIW*k +: AIW]}, {32'h0, outv[k].att});
        end
    endtask

    task automatic model_update();
        bit acc;
        int npop;
        if (clr_i) begin
            q.delete();
        end else begin
            build_inc();
            acc = (valid_i != 2'b00) && (q.size() <= DEPTH - 2);
            if (!(byp_now() && ready_i)) begin
                if (ready_i) begin
                    npop = (q.size() < 2) ? q.size() : 2;
                    repeat (npop) void'(q.pop_front());
                end
                if (acc) foreach (inc[k]) q.push_back(inc[k]);
            end
        end
    endtask

    task automatic drive(input bit c, input logic [1:0] v, input logic [31:0] pc,
                         input bit r, input logic [63:0] ins);
        @(negedge clk);
        clr_i      = c;
        valid_i    = v;
        vpc_i      = pc;
        inst_i     = ins;
        attached_i = $urandom;
        ready_i    = r;
        #1 compare();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
    endtask

    task automatic cyc(input bit c, input logic [1:0] v, input logic [31:0] pc, input bit r);
        drive(c, v, pc, r, {$urandom, $urandom});
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc(1'b0, 2'b00, 32'h0, 1'b1);
        chk("drain_bound", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Mid-run asynchronous reset
        cyc(1'b0, 2'b11, 32'h2000_0000, 1'b0);
        @(negedge clk);
        valid_i = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_o", {62'h0, valid_o}, 64'h0);
        chk("rst_ready_o", {63'h0, ready_o}, 64'h1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Single pair push, then one-cycle visibility and pop
        cyc(1'b0, 2'b11, 32'h1C00_0008, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 1'b1, 64'h0);
        chk("single_valid", {62'h0, valid_o}, 64'h3);
        chk("single_pc0", {32'h0, pc_o[31:0]},  64'h1C00_0008);
        chk("single_pc1", {32'h0, pc_o[63:32]}, 64'h1C00_000C);
        tick();
        drive(1'b0, 2'b00, 32'h0, 1'b1, 64'h0);
        chk("single_after", {62'h0, valid_o}, 64'h0);
        tick();

        // Partial pair compaction
        cyc(1'b0, 2'b10, 32'h1C00_0010, 1'b0);
        cyc(1'b0, 2'b11, 32'h1C00_0018, 1'b0);
        drive(1'b0, 2'b00, 32'h0, 1'b0, 64'h0);
        chk("part_valid", {62'h0, valid_o}, 64'h3);
        chk("part_pc0", {32'h0, pc_o[31:0]},  64'h1C00_0014);
        chk("part_pc1", {32'h0, pc_o[63:32]}, 64'h1C00_0018);
        chk("part_count", 64'(q.size()), 64'd3);
        tick();
        drain();

        // Fill and back-pressure
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b11, 32'h3000_0000 + 32'(8 * i), 1'b0);
        drive(1'b0, 2'b11, 32'h3000_0100, 1'b0, 64'h0);
        chk("full_ready", {63'h0, ready_o}, 64'h0);
        chk("full_valid", {62'h0, valid_o}, 64'h3);
        tick();
        chk("full_count", 64'(q.size()), 64'd8);
        cyc(1'b0, 2'b00, 32'h0, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 1'b1, 64'h0);
        chk("refill_ready", {63'h0, ready_o}, 64'h1);
        tick();
        drain();

        // Wrap-around: walk head/tail to 7, then straddle 7->0
        cyc(1'b1, 2'b00, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 2'b01, 32'h4000_0000 + 32'(8 * i), 1'b0);
            cyc(1'b0, 2'b00, 32'h0, 1'b1);
        end
        cyc(1'b0, 2'b11, 32'h4000_1000, 1'b0);
        drive(1'b0, 2'b11, 32'h4000_2000, 1'b1, {$urandom, $urandom});
        chk("wrap_pc0", {32'h0, pc_o[31:0]},  64'h4000_1000);
        chk("wrap_pc1", {32'h0, pc_o[63:32]}, 64'h4000_1004);
        tick();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 64'h0);
        chk("wrap2_pc0", {32'h0, pc_o[31:0]},  64'h4000_2000);
        chk("wrap2_pc1", {32'h0, pc_o[63:32]}, 64'h4000_2004);
        chk("wrap2_count", 64'(q.size()), 64'd2);
        tick();
        drain();

        // Flush overriding push and pop
        cyc(1'b0, 2'b11, 32'h5000_0000, 1'b0);
        cyc(1'b0, 2'b11, 32'h5000_0008, 1'b0);
        cyc(1'b0, 2'b01, 32'h5000_0010, 1'b0);
        chk("flush_pre", 64'(q.size()), 64'd5);
        cyc(1'b1, 2'b11, 32'h5000_0100, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 1'b0, 64'h0);
        chk("flush_valid", {62'h0, valid_o}, 64'h0);
        chk("flush_ready", {63'h0, ready_o}, 64'h1);
        tick();

        // Empty queue, single slot: same-cycle with bypass, next cycle without
        drive(1'b0, 2'b01, 32'h6000_0000, 1'b1, 64'h0000_0000_0280_0000);
        chk("byp_valid", {62'h0, valid_o}, BYP ? 64'h1 : 64'h0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 1'b1, 64'h0);
        chk("byp_next", {62'h0, valid_o}, BYP ? 64'h0 : 64'h1);
        tick();
        drain();

        // Randomized traffic with phases of varying decode back-pressure
        for (int i = 0; i < 3000; i++) begin
            int ph;
            int pr;
            ph = (i / 200) % 3;
            pr = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
            cyc(($urandom_range(0, 39) == 0),
                2'($urandom_range(0, 3)),
                $urandom,
                ($urandom_range(0, 99) < pr));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/core_fetch_queue.md
Name: core_fetch_queue

Overview:
- Instruction buffer between the I-cache fetch stage and decode.
- Each cycle it accepts an 8-byte-aligned fetch pair (0–2 valid slots) and compacts the valid slots into a circular queue of single-instruction entries.
- Each cycle it presents the oldest two entries to decode.
- Decouples fetch stalls from decode back-pressure and absorbs partial pairs, e.g. a branch target at pc[2]=1.

Parameters:
ATTACHED_INFO_WIDTH, 32, width of per-fetch BPU sideband; copied into every entry of the pair.
DEPTH, 8, number of single-instruction entries; power of two, >= 4.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
clr_i  in  1  flush (branch mispredict / exception redirect)
valid_i  in  2  per-slot valid of the incoming fetch pair
vpc_i  in  32  pair base PC; bits [2:0] are ignored
inst_i  in  64  {slot1, slot0} instruction words
attached_i  in  ATTACHED_INFO_WIDTH  sideband for the pair
ready_o  out  1  queue can accept a full pair this cycle
valid_o  out  2  decode slot valid; only 2'b00, 2'b01 and 2'b11 are legal
pc_o  out  64  {slot1, slot0} PC per output slot
inst_o  out  64  {slot1, slot0} instruction per output slot
attached_o  out  2*ATTACHED_INFO_WIDTH  sideband per output slot
ready_i  in  1  decode accepts every slot flagged in valid_o

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active low, and clears head, tail and count to 0.
- Outputs during and after reset: valid_o=2'b00, ready_o=1. Entry payload storage is not reset.
- Storage: DEPTH entries of {pc[31:0], inst[31:0], attached}. head_q, tail_q are log2(DEPTH) bits and wrap modulo DEPTH; count_q is log2(DEPTH)+1 bits.
- ready_o = (DEPTH - count_q) >= 2. It is computed from registered count only, with no credit for a same-cycle pop.
- Push occurs when |valid_i && ready_o. Valid slots are written in order slot0 then slot1, starting at tail.
  - Entry PC for slot k = {vpc_i[31:3], k[0], 2'b00}.
  - Both entries of a pair receive the same attached_i.
  - push_n = popcount(valid_i). valid_i=2'b10 writes one entry with pc[2]=1.
  - valid_i while ready_o=0 is ignored; upstream must hold.
- Output:
  - valid_o[0] = count_q>=1; valid_o[1] = count_q>=2.
  - Slot0 = entry[head]; slot1 = entry[head+1 mod DEPTH].
  - Outputs come straight from storage (no output register).
- Pop: pop_n = ready_i ? popcount(valid_o) : 0. Decode may not accept only slot0 of two.
- Update rule: count_q <= count_q + push_n - pop_n; head += pop_n; tail += push_n.
  - Push and pop in the same cycle are both honoured.
  - Push when count_q = DEPTH-2 is legal; ready_o then drops the next cycle.
- Latency: a pushed instruction is visible on valid_o the cycle after push (1 cycle) unless the optional bypass is enabled.
- Wrap-around: a two-entry write or read straddling index DEPTH-1 to 0 must be correct.
- clr_i: at the next edge head=tail=count=0, overriding any same-cycle push and pop. The push data of that cycle is discarded. valid_o is 0 the cycle after clr_i.
- Invariants (assertion targets):
  - count_q <= DEPTH.
  - valid_o never equals 2'b10.
  - Stored PCs of consecutive entries from one pair differ by 4.

Optional Feature:
Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count_q==0 and not clr_i, the incoming valid slots are also driven combinationally onto the outputs.
  - Compacted: valid_i=2'b10 appears on output slot0.
  - If ready_i is high that cycle, the bypassed slots are not written (pop_n = push_n, count stays 0). This gives zero-cycle latency through an empty queue.
  - If ready_i is low, the slots are written normally.
- Undefined: no combinational path from valid_i/inst_i to outputs; minimum latency is 1 cycle.

Test Plan:
- Reset and single push: assert rst_n=0 mid-run → valid_o=00, ready_o=1 asynchronously. Release, push valid_i=11, vpc_i=0x1C000008, ready_i=1 → next cycle valid_o=11, pc_o slot0=0x1C000008, slot1=0x1C00000C; the cycle after, valid_o=00.
- Partial pair compaction: push valid_i=10, vpc_i=0x1C000010, then valid_i=11, vpc_i=0x1C000018, with ready_i=0 → valid_o=11, slot0 pc=0x1C000014, slot1 pc=0x1C000018, count=3.
- Fill and back-pressure (DEPTH=8): ready_i=0, push four full pairs → ready_o falls after count reaches 7 or more (8 here), and a fifth pair is not accepted. Raise ready_i → ready_o returns when count<=6, and entries drain in order.
- Wrap-around: with head=7, count=2, slot0 = entry7 and slot1 = entry0. Simultaneous pop of 2 and push of 2 → count stays 2, head=1, tail advances by 2 modulo 8.
- Flush: count=5, assert clr_i together with valid_i=11 and ready_i=1 → next cycle count=0, valid_o=00, the pushed pair is absent, ready_o=1.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, ready_i=1, valid_i=01, inst=0x02800000 → same cycle valid_o=01, inst_o slot0=0x02800000; next cycle count=0. Without the macro, valid_o rises one cycle later.
